pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the pipelined CPU, replacing the fixed 5-stage hazard logic with one block that supports configurable pipeline depth and a multi-cycle execute unit. Sits beside the stage registers: it takes decoded ID-stage operand/destination info and the EX-stage redirect, and drives the PC/IFID write enables, IFID/IDEX/EXMEM flush/bubble controls and EX operand forwarding selects. It keeps its own registered tag pipeline mirroring the stage registers, plus stall and flush statistics counters.

## Interface

Parameters:
- NUM_STAGES, 5, pipeline depth; stage 0 = IF, 1 = ID, 2 = EX, 3 = MEM, NUM_STAGES-1 = WB; legal range 5..8
- REG_ADDR_W, 5, register address width
- MUL_LAT, 3, cycles a multi-cycle op occupies EX; legal range 1..15
- SEL_W, $clog2(NUM_STAGES), width of forwarding selects

Ports:
- Clock  in  1  system clock (ClkOut domain)
- Reset  in  1  synchronous, active-high reset
- ID_Valid  in  1  IFID holds a real instruction
- ID_Rs, ID_Rt  in  REG_ADDR_W  source register addresses
- ID_UsesRs, ID_UsesRt  in  1  source actually read
- ID_Dest  in  REG_ADDR_W  destination register
- ID_RegWrite  in  1  instruction writes ID_Dest
- ID_IsLoad  in  1  memory load
- ID_IsMulti  in  1  multi-cycle EX op
- Redirect  in  1  taken branch/jump resolved in EX
- PC_WriteEnable  out  1  PC may update
- IFID_WriteEnable  out  1  IFID may load
- IFID_Flush  out  1  clear IFID
- IDEX_Bubble  out  1  load a NOP into IDEX
- IDEX_WriteEnable  out  1  IDEX may load
- EXMEM_Bubble  out  1  load a NOP into EXMEM
- Busy  out  1  multi-cycle op holding EX
- FwdA_Sel, FwdB_Sel  out  SEL_W  EX operand source: 0 = register file, k = stage k (3..NUM_STAGES-1)
- Stall_Count  out  16  saturating count of stall cycles
- Flush_Count  out  16  saturating count of accepted redirects

## Operation

- Tag entry per stage k = 2..NUM_STAGES-1: valid, regwrite, dest, isload; EX entry (k = 2) also holds rs, rt, usesrs, usesrt, ismulti.
- Register 0 never matches in any hazard or forward comparison.
- Multi-cycle counter Count (4 bits). When an is_multi instruction is written into the EX entry, Count loads MUL_LAT-1. Busy = (Count != 0). Count decrements each cycle while non-zero.
- Load-use hazard (LU): ID_Valid, EX valid and isload and regwrite, and EX dest equals ID_Rs (with ID_UsesRs) or ID_Rt (with ID_UsesRt).
- Priority per cycle, highest first:
  - Busy: PC_WriteEnable = IFID_WriteEnable = IDEX_WriteEnable = 0, IDEX_Bubble = 0, EXMEM_Bubble = 1. Stages 0..2 hold; stage 3 gets an invalid entry; later stages shift. Redirect during Busy is illegal and ignored; Flush_Count is unchanged.
  - Redirect: IFID_Flush = 1, IDEX_Bubble = 1, PC_WriteEnable = 1. The EX entry becomes invalid and older entries shift. Flush_Count increments. LU is ignored.
  - LU: PC_WriteEnable = IFID_WriteEnable = 0, IDEX_Bubble = 1. The EX entry becomes invalid and older entries shift.
  - Otherwise: all write enables are 1, no flush or bubble. The EX entry loads the ID info qualified by ID_Valid, and entries shift k -> k+1.
- Forwarding, EX operand A (B is identical with rt): FwdA_Sel = smallest k in 3..NUM_STAGES-1 where entry k is valid, regwrite and dest == EX rs, with EX usesrs and the EX entry valid. If no stage matches, FwdA_Sel = 0. The youngest producer wins.
- Stall_Count increments each cycle PC_WriteEnable = 0 and saturates at 0xFFFF. Flush_Count saturates at 0xFFFF.

## Timing

- The tag pipeline, Count and both statistics counters are registered.
- All control and select outputs are combinational from the registered state, the ID inputs and Redirect; zero-cycle latency within the cycle.
- Reset, synchronous: all entries invalid, Count = 0, both statistics counters = 0.
- Outputs after the reset edge: PC_WriteEnable = IFID_WriteEnable = IDEX_WriteEnable = 1; IFID_Flush, IDEX_Bubble, EXMEM_Bubble and Busy = 0; FwdA_Sel = FwdB_Sel = 0.
- Reset during Busy aborts the op immediately; Busy = 0 in the next cycle.
- A multi-cycle op occupies EX for exactly MUL_LAT cycles and sets Busy for MUL_LAT-1 of them. MUL_LAT = 1 never sets Busy.
- A load followed directly by a dependent instruction costs exactly 1 stall cycle; the dependent instruction then gets FwdSel = 4 (MEM/WB) when NUM_STAGES = 5.

## Test plan

- Back-to-back ALU dependency: add r3 then sub r4,r3,r1 -> the cycle sub is in EX has FwdA_Sel = 3. One instruction later, a third dependent instruction gets FwdA_Sel = 4. No stalls.
- Load-use: lw r5 then add r6,r5,r2 -> one cycle with PC_WriteEnable = 0 and IDEX_Bubble = 1, Stall_Count = 1, then FwdA_Sel = 4.
- Redirect coinciding with LU -> IFID_Flush = 1, IDEX_Bubble = 1, PC_WriteEnable = 1, Flush_Count = 1, Stall_Count unchanged.
- MUL_LAT = 3, multi op enters EX -> Busy = 1 for 2 cycles with EXMEM_Bubble = 1 and Stall_Count += 2; the op leaves EX on the third edge.
- NUM_STAGES = 7, producer in stage 6 only -> FwdB_Sel = 6. Writes to r0 never forward (select = 0).
- Reset asserted mid-Busy -> the next cycle shows Busy = 0, all selects 0, and both counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard, forwarding and stall controller with a registered tag pipeline
// Ports: Clock/Reset (sync, active-high); ID_* decoded ID-stage operand/destination info;
// Redirect taken branch from EX; PC/IFID/IDEX write enables, IFID_Flush, IDEX/EXMEM bubbles;
// Busy multi-cycle EX hold; FwdA_Sel/FwdB_Sel EX operand sources; Stall_Count/Flush_Count stats.
module pipeline_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT = 3,
  parameter int SEL_W = $clog2(NUM_STAGES)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] ID_Dest,
  input  logic                  ID_RegWrite,
  input  logic                  ID_IsLoad,
  input  logic                  ID_IsMulti,
  input  logic                  Redirect,
  output logic                  PC_WriteEnable,
  output logic                  IFID_WriteEnable,
  output logic                  IFID_Flush,
  output logic                  IDEX_Bubble,
  output logic                  IDEX_WriteEnable,
  output logic                  EXMEM_Bubble,
  output logic                  Busy,
  output logic [SEL_W-1:0]      FwdA_Sel,
  output logic [SEL_W-1:0]      FwdB_Sel,
  output logic [15:0]           Stall_Count,
  output logic [15:0]           Flush_Count
);
  logic [NUM_STAGES-1:2] tValid, tRegWrite;
  logic [REG_ADDR_W-1:0] tDest [2:NUM_STAGES-1];
  logic [REG_ADDR_W-1:0] exRs, exRt;
  logic exUsesRs, exUsesRt, exIsLoad;
  logic [3:0] count;
  logic loadUse, fire, advance;
  assign Busy = count != 4'd0;
  always_comb begin
    loadUse = ID_Valid && tValid[2] && exIsLoad && tRegWrite[2] && tDest[2] != '0 &&
              ((tDest[2] == ID_Rs && ID_UsesRs) || (tDest[2] == ID_Rt && ID_UsesRt));
    fire = Redirect && !Busy;
    advance = !Busy && !Redirect && !loadUse;
    PC_WriteEnable = !Busy && (Redirect || !loadUse);
    IFID_WriteEnable = PC_WriteEnable;
    IFID_Flush = fire;
    IDEX_Bubble = !Busy && (Redirect || loadUse);
    IDEX_WriteEnable = !Busy;
    EXMEM_Bubble = Busy;
  end
  // descending scan so the youngest producer (smallest stage) wins
  always_comb begin
    FwdA_Sel = '0;
    FwdB_Sel = '0;
    for (int k = NUM_STAGES-1; k >= 3; k--) begin
      if (tValid[k] && tRegWrite[k] && tDest[k] != '0) begin
        if (tValid[2] && exUsesRs && tDest[k] == exRs) FwdA_Sel = SEL_W'(k);
        if (tValid[2] && exUsesRt && tDest[k] == exRt) FwdB_Sel = SEL_W'(k);
      end
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tValid <= '0;
      count <= '0;
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (!PC_WriteEnable && Stall_Count != 16'hFFFF) Stall_Count <= Stall_Count + 16'd1;
      if (fire && Flush_Count != 16'hFFFF) Flush_Count <= Flush_Count + 16'd1;
      count <= Busy ? count - 4'd1 : (advance && ID_Valid && ID_IsMulti) ? 4'(MUL_LAT-1) : 4'd0;
      for (int k = NUM_STAGES-1; k >= 4; k--) begin
        tValid[k] <= tValid[k-1];
        tRegWrite[k] <= tRegWrite[k-1];
        tDest[k] <= tDest[k-1];
      end
      tValid[3] <= tValid[2] && !Busy;
      tRegWrite[3] <= tRegWrite[2];
      tDest[3] <= tDest[2];
      if (!Busy) begin
        tValid[2] <= advance && ID_Valid;
        tRegWrite[2] <= ID_RegWrite;
        tDest[2] <= ID_Dest;
        exRs <= ID_Rs;
        exRt <= ID_Rt;
        exUsesRs <= ID_UsesRs;
        exUsesRt <= ID_UsesRt;
        exIsLoad <= ID_IsLoad;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vector bench for pipeline_hazard_ctrl (5-stage and 7-stage/MUL_LAT=1)
module tb_pipeline_hazard_ctrl;
  logic Clock = 0, Reset;
  logic ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_IsLoad, ID_IsMulti, Redirect;
  logic [4:0] ID_Rs, ID_Rt, ID_Dest;
  logic pcWe, ifidWe, ifidFlush, idexBubble, idexWe, exmemBubble, busy;
  logic [2:0] fwdA, fwdB;
  logic [15:0] stallCnt, flushCnt;
  logic pcWe7, ifidWe7, ifidFlush7, idexBubble7, idexWe7, exmemBubble7, busy7;
  logic [2:0] fwdA7, fwdB7;
  logic [15:0] stallCnt7, flushCnt7;
  int passCnt = 0, totalCnt = 0;
  always #5 Clock = ~Clock;
  pipeline_hazard_ctrl dut (
    .Clock(Clock), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Dest(ID_Dest), .ID_RegWrite(ID_RegWrite),
    .ID_IsLoad(ID_IsLoad), .ID_IsMulti(ID_IsMulti), .Redirect(Redirect),
    .PC_WriteEnable(pcWe), .IFID_WriteEnable(ifidWe), .IFID_Flush(ifidFlush),
    .IDEX_Bubble(idexBubble), .IDEX_WriteEnable(idexWe), .EXMEM_Bubble(exmemBubble),
    .Busy(busy), .FwdA_Sel(fwdA), .FwdB_Sel(fwdB), .Stall_Count(stallCnt), .Flush_Count(flushCnt)
  );
  pipeline_hazard_ctrl #(.NUM_STAGES(7), .MUL_LAT(1)) dut7 (
    .Clock(Clock), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Dest(ID_Dest), .ID_RegWrite(ID_RegWrite),
    .ID_IsLoad(ID_IsLoad), .ID_IsMulti(ID_IsMulti), .Redirect(Redirect),
    .PC_WriteEnable(pcWe7), .IFID_WriteEnable(ifidWe7), .IFID_Flush(ifidFlush7),
    .IDEX_Bubble(idexBubble7), .IDEX_WriteEnable(idexWe7), .EXMEM_Bubble(exmemBubble7),
    .Busy(busy7), .FwdA_Sel(fwdA7), .FwdB_Sel(fwdB7), .Stall_Count(stallCnt7), .Flush_Count(flushCnt7)
  );
  typedef struct {
    logic v; logic [4:0] rs, rt; logic ur, ut; logic [4:0] d; logic rw, ld, mu, rd;
    logic [6:0] ctl; logic [2:0] fa, fb; logic [15:0] sc, fc;
  } vec_t;
  localparam logic [6:0] NRM = 7'b1100100, LDU = 7'b0001100, RED = 7'b1111100, BSY = 7'b0000011;
  vec_t vecs [20];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic ut, input logic [4:0] d, input logic rw, input logic ld,
                       input logic mu, input logic rd);
    ID_Valid = v; ID_Rs = rs; ID_Rt = rt; ID_UsesRs = ur; ID_UsesRt = ut;
    ID_Dest = d; ID_RegWrite = rw; ID_IsLoad = ld; ID_IsMulti = mu; Redirect = rd;
  endtask
  initial begin
    vecs[0]  = '{1, 1, 2, 1, 1, 3, 1, 0, 0, 0, NRM, 0, 0, 0, 0};
    vecs[1]  = '{1, 3, 1, 1, 1, 4, 1, 0, 0, 0, NRM, 0, 0, 0, 0};
    vecs[2]  = '{1, 3, 4, 1, 1, 7, 1, 0, 0, 0, NRM, 3, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 4, 3, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0, 0};
    vecs[5]  = '{1, 1, 0, 1, 0, 5, 1, 1, 0, 0, NRM, 0, 0, 0, 0};
    vecs[6]  = '{1, 5, 2, 1, 1, 6, 1, 0, 0, 0, LDU, 0, 0, 0, 0};
    vecs[7]  = '{1, 5, 2, 1, 1, 6, 1, 0, 0, 0, NRM, 0, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 4, 0, 1, 0};
    vecs[9]  = '{1, 1, 0, 1, 0, 8, 1, 1, 0, 0, NRM, 0, 0, 1, 0};
    vecs[10] = '{1, 8, 8, 1, 1, 9, 1, 0, 0, 1, RED, 0, 0, 1, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 1, 1};
    vecs[12] = '{1, 1, 2, 1, 1, 10, 1, 0, 1, 0, NRM, 0, 0, 1, 1};
    vecs[13] = '{1, 10, 3, 1, 1, 11, 1, 0, 0, 0, BSY, 0, 0, 1, 1};
    vecs[14] = '{1, 10, 3, 1, 1, 11, 1, 0, 0, 0, BSY, 0, 0, 2, 1};
    vecs[15] = '{1, 10, 3, 1, 1, 11, 1, 0, 0, 0, NRM, 0, 0, 3, 1};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 3, 0, 3, 1};
    vecs[17] = '{1, 1, 1, 1, 1, 0, 1, 0, 0, 0, NRM, 0, 0, 3, 1};
    vecs[18] = '{1, 0, 0, 1, 1, 12, 1, 0, 0, 0, NRM, 0, 0, 3, 1};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 3, 1};
    Reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge Clock);
    Reset = 0;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].ut, vecs[i].d,
            vecs[i].rw, vecs[i].ld, vecs[i].mu, vecs[i].rd);
      #1;
      check($sformatf("vec%0d", i),
            64'({pcWe, ifidWe, ifidFlush, idexBubble, idexWe, exmemBubble, busy, fwdA, fwdB, stallCnt, flushCnt}),
            64'({vecs[i].ctl, vecs[i].fa, vecs[i].fb, vecs[i].sc, vecs[i].fc}));
      @(negedge Clock);
    end
    drive(1, 1, 2, 1, 1, 13, 1, 0, 1, 0);
    @(negedge Clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("busy_before_reset", 64'(busy), 64'(1));
    Reset = 1;
    @(negedge Clock);
    Reset = 0;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_ctl", 64'({pcWe, ifidWe, ifidFlush, idexBubble, idexWe, exmemBubble}), 64'(6'b110010));
    check("reset_sel", 64'({fwdA, fwdB}), 64'(0));
    check("reset_counters", 64'({stallCnt, flushCnt}), 64'(0));
    @(negedge Clock);
    drive(1, 1, 2, 1, 1, 9, 1, 0, 0, 0);
    @(negedge Clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge Clock);
    drive(1, 1, 9, 1, 1, 14, 1, 0, 0, 0);
    @(negedge Clock);
    drive(1, 1, 2, 1, 1, 15, 1, 0, 1, 0);
    #1;
    check("s7_fwdB_stage6", 64'(fwdB7), 64'(6));
    check("s7_fwdA_none", 64'(fwdA7), 64'(0));
    check("s5_fwdB_retired", 64'(fwdB), 64'(0));
    @(negedge Clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("s7_mullat1_busy", 64'(busy7), 64'(0));
    check("s7_mullat1_pcwe", 64'(pcWe7), 64'(1));
    check("s5_mul_busy", 64'(busy), 64'(1));
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
